sprite_blitter: RTL and testbench

//  Executes blit commands issued by the CHIP-8 CPU (DXYN draws, screen clears) against the display framebuffer.

---
 rtl/sprite_blitter_pkg.sv | 26 ++
 rtl/sprite_row_shift.sv | 23 ++
 rtl/sprite_blitter.sv | 209 ++++++++++++++++++++
 tb/tb_sprite_blitter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_blitter_pkg.sv
// rtl/sprite_blitter_pkg.sv - blit command codes, screen geometry and sequencer states
package sprite_blitter_pkg;

  localparam logic [2:0] BLIT_OP_NONE   = 3'd0;
  localparam logic [2:0] BLIT_OP_SPRITE = 3'd1;
  localparam logic [2:0] BLIT_OP_CLEAR  = 3'd2;

  localparam logic [6:0] SCREEN_H_HI   = 7'd64;
  localparam logic [6:0] SCREEN_H_LO   = 7'd32;
  localparam logic [4:0] ROW_BYTES_HI  = 5'd16;
  localparam logic [4:0] ROW_BYTES_LO  = 5'd8;
  localparam logic [5:0] WIDE_SLICES   = 6'd32;

  typedef enum logic [3:0] {
    ST_IDLE, ST_CLR_START, ST_CLR, ST_SPR_START,
    ST_SRC, ST_SRC_W, ST_RDL, ST_RDL_W, ST_RDR, ST_RDR_W,
    ST_WRL, ST_WRR, ST_NEXT, ST_DONE
  } state_e;

  // 16x16 sprites spend two slices (left half, right half) per screen row
  function automatic logic [6:0] slice_row(input logic [5:0] y, input logic [5:0] s,
                                           input logic wide);
    return {1'b0, y} + (wide ? {3'b000, s[4:1]} : {3'b000, s[3:0]});
  endfunction

endpackage

// File: rtl/sprite_row_shift.sv
// rtl/sprite_row_shift.sv - splits one sprite byte across two framebuffer bytes with right-edge clipping
module sprite_row_shift (
  input  logic [7:0] spr,
  input  logic [2:0] xoff,
  input  logic [4:0] lbyte,
  input  logic [4:0] row_bytes,
  output logic [7:0] left_bits,
  output logic [7:0] right_bits,
  output logic       left_ok,
  output logic       right_ok
);

  logic [15:0] shifted;

  always_comb begin
    shifted    = {spr, 8'h00} >> xoff;
    left_ok    = ({1'b0, lbyte} < {1'b0, row_bytes});
    right_ok   = (xoff != 3'd0) && (({1'b0, lbyte} + 6'd1) < {1'b0, row_bytes});
    left_bits  = left_ok  ? shifted[15:8] : 8'h00;
    right_bits = right_ok ? shifted[7:0]  : 8'h00;
  end

endmodule

// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - executes CHIP-8 sprite draws and screen clears against the byte-wide framebuffer
module sprite_blitter
  import sprite_blitter_pkg::*;
#(
  parameter int RAM_AW = 12,
  parameter int FB_AW  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hires,
  input  logic [2:0]        blit_op,
  input  logic [RAM_AW-1:0] blit_src,
  input  logic [3:0]        blit_srcHeight,
  input  logic [6:0]        blit_destX,
  input  logic [5:0]        blit_destY,
  input  logic              blit_enable,
  output logic              busy,
  output logic              done,
  output logic              collision,
  output logic              mem_en,
  output logic [RAM_AW-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              fb_en,
  output logic              fb_wr,
  output logic [FB_AW-1:0]  fb_addr,
  output logic [7:0]        fb_wdata,
  input  logic [7:0]        fb_rdata
);

  state_e            state_q, state_d;
  logic [RAM_AW-1:0] src_q, src_d;
  logic [5:0]        nslices_q, nslices_d, slice_q, slice_d;
  logic [6:0]        x_q, x_d;
  logic [5:0]        y_q, y_d;
  logic              hires_q, hires_d, wide_q, wide_d, collision_q, collision_d;
  logic [7:0]        spr_q, spr_d, old_l_q, old_l_d, old_r_q, old_r_d;
  logic [FB_AW-1:0]  clr_q, clr_d;

  logic [7:0] xs, left_bits, right_bits;
  logic [4:0] lbyte, rbyte, row_bytes;
  logic [6:0] row, height;
  logic [5:0] slice_sel;
  logic       slice_live, left_ok, right_ok;

  assign height     = hires_q ? SCREEN_H_HI : SCREEN_H_LO;
  assign row_bytes  = hires_q ? ROW_BYTES_HI : ROW_BYTES_LO;
  assign xs         = {1'b0, x_q} + ((wide_q && slice_q[0]) ? 8'd8 : 8'd0);
  assign lbyte      = xs[7:3];
  assign rbyte      = lbyte + 5'd1;
  assign row        = slice_row(y_q, slice_q, wide_q);
  // NEXT looks ahead to the slice it is about to start
  assign slice_sel  = (state_q == ST_NEXT) ? slice_q + 6'd1 : slice_q;
  assign slice_live = (slice_sel < nslices_q) && (slice_row(y_q, slice_sel, wide_q) < height);
  assign busy       = (state_q != ST_IDLE);
  assign collision  = collision_q;

  sprite_row_shift u_shift (
    .spr       (spr_q),
    .xoff      (xs[2:0]),
    .lbyte     (lbyte),
    .row_bytes (row_bytes),
    .left_bits (left_bits),
    .right_bits(right_bits),
    .left_ok   (left_ok),
    .right_ok  (right_ok)
  );

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    nslices_d   = nslices_q;
    slice_d     = slice_q;
    x_d         = x_q;
    y_d         = y_q;
    hires_d     = hires_q;
    wide_d      = wide_q;
    collision_d = collision_q;
    spr_d       = spr_q;
    old_l_d     = old_l_q;
    old_r_d     = old_r_q;
    clr_d       = clr_q;
    done        = 1'b0;
    mem_en      = 1'b0;
    mem_addr    = '0;
    fb_en       = 1'b0;
    fb_wr       = 1'b0;
    fb_addr     = '0;
    fb_wdata    = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (blit_enable) begin
          src_d     = blit_src;
          hires_d   = hires;
          x_d       = hires ? blit_destX : {1'b0, blit_destX[5:0]};
          y_d       = hires ? blit_destY : {1'b0, blit_destY[4:0]};
          wide_d    = hires && (blit_srcHeight == 4'd0);
          nslices_d = (hires && (blit_srcHeight == 4'd0)) ? WIDE_SLICES : {2'b00, blit_srcHeight};
          slice_d   = 6'd0;
          case (blit_op)
            BLIT_OP_SPRITE: state_d = ST_SPR_START;
            BLIT_OP_CLEAR:  state_d = ST_CLR_START;
            default:        state_d = ST_DONE;
          endcase
        end
      end
      ST_CLR_START: begin
        collision_d = 1'b0;
        clr_d       = '0;
        state_d     = ST_CLR;
      end
      ST_CLR: begin
        fb_en   = 1'b1;
        fb_wr   = 1'b1;
        fb_addr = clr_q;
        clr_d   = clr_q + 1'b1;
        if (&clr_q) state_d = ST_DONE;
      end
      ST_SPR_START: begin
        collision_d = 1'b0;
        state_d     = slice_live ? ST_SRC : ST_DONE;
      end
      ST_SRC: begin
        mem_en   = 1'b1;
        mem_addr = src_q + RAM_AW'(slice_q);
        state_d  = ST_SRC_W;
      end
      ST_SRC_W: begin
        spr_d   = mem_data;
        state_d = ST_RDL;
      end
      ST_RDL: begin
        fb_en   = left_ok;
        fb_addr = FB_AW'({row[5:0], lbyte[3:0]});
        state_d = ST_RDL_W;
      end
      ST_RDL_W: begin
        old_l_d = fb_rdata;
        state_d = ST_RDR;
      end
      ST_RDR: begin
        fb_en   = right_ok;
        fb_addr = FB_AW'({row[5:0], rbyte[3:0]});
        state_d = ST_RDR_W;
      end
      ST_RDR_W: begin
        old_r_d = fb_rdata;
        state_d = ST_WRL;
      end
      ST_WRL: begin
        fb_en       = left_ok;
        fb_wr       = left_ok;
        fb_addr     = FB_AW'({row[5:0], lbyte[3:0]});
        fb_wdata    = old_l_q ^ left_bits;
        collision_d = collision_q | (|(old_l_q & left_bits));
        state_d     = ST_WRR;
      end
      ST_WRR: begin
        fb_en       = right_ok;
        fb_wr       = right_ok;
        fb_addr     = FB_AW'({row[5:0], rbyte[3:0]});
        fb_wdata    = old_r_q ^ right_bits;
        collision_d = collision_q | (|(old_r_q & right_bits));
        state_d     = ST_NEXT;
      end
      ST_NEXT: begin
        slice_d = slice_q + 6'd1;
        state_d = slice_live ? ST_SRC : ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      src_q       <= '0;
      nslices_q   <= '0;
      slice_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      hires_q     <= 1'b0;
      wide_q      <= 1'b0;
      collision_q <= 1'b0;
      spr_q       <= '0;
      old_l_q     <= '0;
      old_r_q     <= '0;
      clr_q       <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      nslices_q   <= nslices_d;
      slice_q     <= slice_d;
      x_q         <= x_d;
      y_q         <= y_d;
      hires_q     <= hires_d;
      wide_q      <= wide_d;
      collision_q <= collision_d;
      spr_q       <= spr_d;
      old_l_q     <= old_l_d;
      old_r_q     <= old_r_d;
      clr_q       <= clr_d;
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - directed bench for sprite_blitter with program RAM and framebuffer models
module tb_sprite_blitter;
  import sprite_blitter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hires;
  logic [2:0]  blit_op;
  logic [11:0] blit_src;
  logic [3:0]  blit_srcHeight;
  logic [6:0]  blit_destX;
  logic [5:0]  blit_destY;
  logic        blit_enable;
  logic        busy, done, collision;
  logic        mem_en;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data;
  logic        fb_en, fb_wr;
  logic [9:0]  fb_addr;
  logic [7:0]  fb_wdata, fb_rdata;

  logic [7:0]  pmem [0:4095];
  logic [7:0]  fbm  [0:1023];
  logic        tb_wr_en;
  logic [9:0]  tb_wr_addr;
  logic [7:0]  tb_wr_data;
  logic        log_clr;
  int          mlog_n;
  logic [11:0] mlog0, mlog1, mlog_last;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  sprite_blitter dut (
    .clk(clk), .rst_n(rst_n), .hires(hires), .blit_op(blit_op), .blit_src(blit_src),
    .blit_srcHeight(blit_srcHeight), .blit_destX(blit_destX), .blit_destY(blit_destY),
    .blit_enable(blit_enable), .busy(busy), .done(done), .collision(collision),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .fb_en(fb_en), .fb_wr(fb_wr), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_rdata(fb_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) mem_data <= pmem[mem_addr];
    if (fb_en) begin
      if (fb_wr) fbm[fb_addr] <= fb_wdata;
      else       fb_rdata     <= fbm[fb_addr];
    end
    if (tb_wr_en) fbm[tb_wr_addr] <= tb_wr_data;
    if (log_clr) mlog_n <= 0;
    else if (mem_en) begin
      if (mlog_n == 0) mlog0 <= mem_addr;
      if (mlog_n == 1) mlog1 <= mem_addr;
      mlog_last <= mem_addr;
      mlog_n    <= mlog_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_wr_en = 1'b1; tb_wr_addr = a; tb_wr_data = d;
    @(negedge clk);
    tb_wr_en = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic h, input logic [11:0] src,
                       input logic [3:0] ht, input logic [6:0] x, input logic [5:0] y);
    @(negedge clk);
    blit_op = op; hires = h; blit_src = src; blit_srcHeight = ht;
    blit_destX = x; blit_destY = y; blit_enable = 1'b1;
  endtask

  // returns cycles from the strobe edge to the done pulse, -1 on timeout
  task automatic wait_done(input int start, output int lat);
    lat = start;
    while (!done && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic h, input logic [11:0] src,
                         input logic [3:0] ht, input logic [6:0] x, input logic [5:0] y,
                         output int lat);
    issue(op, h, src, ht, x, y);
    @(negedge clk);
    blit_enable = 1'b0;
    wait_done(1, lat);
  endtask

  initial begin
    int lat, wcnt, guard, extra;
    rst_n = 1'b0; hires = 1'b0; blit_op = BLIT_OP_NONE; blit_src = '0; blit_srcHeight = '0;
    blit_destX = '0; blit_destY = '0; blit_enable = 1'b0;
    tb_wr_en = 1'b0; tb_wr_addr = '0; tb_wr_data = '0; log_clr = 1'b1;
    for (int i = 0; i < 4096; i++) pmem[i] = 8'h00;
    pmem[12'h200] = 8'hFF;
    for (int i = 0; i < 4; i++) pmem[12'h300 + i] = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      pmem[12'h400 + 2*i]     = 8'hC0;
      pmem[12'h400 + 2*i + 1] = 8'h03;
    end
    pmem[12'h500] = 8'h81;

    repeat (3) @(negedge clk);
    check("rst_busy_done_coll", {busy, done, collision}, 3'b000);
    check("rst_strobes", {mem_en, fb_en, fb_wr}, 3'b000);
    check("rst_addr_data", {mem_addr, fb_addr, fb_wdata}, 30'd0);
    rst_n = 1'b1;
    log_clr = 1'b0;

    // reset lands in the middle of a clear
    poke(10'd0, 8'h11);
    poke(10'd300, 8'h5A);
    poke(10'd1023, 8'h77);
    issue(BLIT_OP_CLEAR, 1'b1, 12'h0, 4'd0, 7'd0, 6'd0);
    @(negedge clk);
    blit_enable = 1'b0;
    wcnt = 0; guard = 0;
    while (wcnt < 100 && guard < 500) begin
      if (fb_wr) wcnt++;
      if (wcnt < 100) @(negedge clk);
      guard++;
    end
    check("t1_reached_100_writes", wcnt, 100);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t1_async_busy", busy, 1'b0);
    check("t1_async_fb_wr", {fb_wr, fb_en}, 2'b00);
    check("t1_partial_byte0", fbm[0], 8'h00);
    check("t1_partial_byte300", fbm[300], 8'h5A);
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(BLIT_OP_CLEAR, 1'b1, 12'h0, 4'd0, 7'd0, 6'd0, lat);
    check("t1_clear_latency", lat, 1026);
    check("t1_clear_coll", collision, 1'b0);
    @(negedge clk);
    check("t1_done_one_cycle", {done, busy}, 2'b00);
    check("t1_clear_byte300", fbm[300], 8'h00);
    check("t1_clear_byte1023", fbm[1023], 8'h00);

    // hires X=3 single row on empty buffer, then the same draw erases it
    run_cmd(BLIT_OP_SPRITE, 1'b1, 12'h200, 4'd1, 7'd3, 6'd0, lat);
    check("t2_latency", lat, 11);
    check("t2_collision", collision, 1'b0);
    @(negedge clk);
    check("t2_byte0", fbm[0], 8'h1F);
    check("t2_byte1", fbm[1], 8'hE0);
    run_cmd(BLIT_OP_SPRITE, 1'b1, 12'h200, 4'd1, 7'd3, 6'd0, lat);
    check("t3_latency", lat, 11);
    check("t3_collision", collision, 1'b1);
    @(negedge clk);
    check("t3_bytes", {fbm[0], fbm[1]}, 16'h0000);

    // unknown op leaves collision alone
    run_cmd(3'd5, 1'b1, 12'h0, 4'd1, 7'd0, 6'd0, lat);
    check("t6_unknown_latency", lat, 1);
    check("t6_unknown_coll_held", collision, 1'b1);

    // lores clipping at bottom-right corner
    poke(10'd488, 8'hA5);
    run_cmd(BLIT_OP_SPRITE, 1'b0, 12'h300, 4'd4, 7'd60, 6'd30, lat);
    check("t4_latency", lat, 20);
    check("t4_collision", collision, 1'b0);
    @(negedge clk);
    check("t4_row30_byte7", fbm[487], 8'h0F);
    check("t4_row31_byte7", fbm[503], 8'h0F);
    check("t4_row30_byte8_untouched", fbm[488], 8'hA5);
    check("t4_row31_byte8_untouched", fbm[504], 8'h00);
    check("t4_row32_untouched", fbm[519], 8'h00);

    // hires 16x16 with wrapped coordinates (130,66) -> (2,2)
    log_clr = 1'b1;
    @(negedge clk);
    log_clr = 1'b0;
    run_cmd(BLIT_OP_SPRITE, 1'b1, 12'h400, 4'd0, 7'(130), 6'(66), lat);
    check("t5_latency", lat, 290);
    check("t5_collision", collision, 1'b0);
    check("t5_fetch_count", mlog_n, 32);
    check("t5_fetch_first_two", {mlog0, mlog1}, {12'h400, 12'h401});
    check("t5_fetch_last", mlog_last, 12'h41F);
    @(negedge clk);
    check("t5_row2_bytes", {fbm[32], fbm[33], fbm[34]}, 24'h3000C0);
    check("t5_row17_bytes", {fbm[272], fbm[274]}, 16'h30C0);
    check("t5_row18_empty", {fbm[288], fbm[290]}, 16'h0000);

    // second strobe while busy must be dropped
    issue(BLIT_OP_SPRITE, 1'b1, 12'h500, 4'd1, 7'd0, 6'd40);
    @(negedge clk);
    blit_enable = 1'b0;
    repeat (2) @(negedge clk);
    blit_op = BLIT_OP_CLEAR;
    blit_enable = 1'b1;
    @(negedge clk);
    blit_enable = 1'b0;
    wait_done(4, lat);
    check("t6_busy_latency", lat, 11);
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("t6_no_extra_done", extra, 0);
    check("t6_idle_after", busy, 1'b0);
    check("t6_sprite_drawn", fbm[640], 8'h81);
    check("t6_not_cleared", fbm[487], 8'h0F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
